// File: rtl/vmac_pkg.sv
// Shared definitions for the vmac_dot_acc streaming dot-product stage.
//   LEN_DEFAULT   : default number of products per group
//   ACC_W_DEFAULT : default accumulator / output sum width
//   PROD_W        : width of the 8x8 multiplier product
//   state_t       : accumulator-side FSM states (IDLE = no partial group)
package vmac_pkg;

    localparam int LEN_DEFAULT   = 16;
    localparam int ACC_W_DEFAULT = 24;
    localparam int PROD_W        = 16;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/vedic8bit.sv
// Unsigned 8x8 Vedic (Urdhva Tiryagbhyam) multiplier, purely combinational.
// Built as 2x2 -> 4x4 -> 8x8: each level forms four half-width partial
// products and adds them at their crosswise weights.
//   a, b : 8-bit unsigned operands
//   p    : 16-bit unsigned product
module vedic2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic t_hl, t_lh, t_hh, c1;

    assign t_hl = a[1] & b[0];
    assign t_lh = a[0] & b[1];
    assign t_hh = a[1] & b[1];
    assign c1   = t_hl & t_lh;

    assign p[0] = a[0] & b[0];
    assign p[1] = t_hl ^ t_lh;
    assign p[2] = t_hh ^ c1;
    assign p[3] = t_hh & c1;
endmodule

module vedic4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q_ll, q_hl, q_lh, q_hh;

    vedic2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q_ll));
    vedic2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q_hl));
    vedic2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q_lh));
    vedic2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q_hh));

    assign p = {4'b0, q_ll} + {2'b0, q_hl, 2'b0} + {2'b0, q_lh, 2'b0} + {q_hh, 4'b0};
endmodule

module vedic8bit (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [7:0] q_ll, q_hl, q_lh, q_hh;

    vedic4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(q_ll));
    vedic4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(q_hl));
    vedic4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(q_lh));
    vedic4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(q_hh));

    assign p = {8'b0, q_ll} + {4'b0, q_hl, 4'b0} + {4'b0, q_lh, 4'b0} + {q_hh, 8'b0};
endmodule

// File: rtl/vmac_dot_acc.sv
// Streaming dot-product stage around the vedic8bit multiplier.
// Operand pairs are registered (stage 1), multiplied combinationally and
// accumulated over groups of LEN products; each group sum is presented on a
// valid/ready output. Only the last element of a group can be stalled, so at
// most one finished result is ever waiting for the consumer.
//
// Build option: define VMAC_SATURATE_EN to clamp the accumulator at
// 2^ACC_W-1 on overflow (default build wraps modulo 2^ACC_W).
//
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : operand handshake, in_a/in_b unsigned 8-bit
//   out_valid/out_ready : result handshake
//   out_sum             : ACC_W-bit group sum
//   out_ovf             : group overflowed ACC_W (sticky within the group)
module vmac_dot_acc
    import vmac_pkg::*;
#(
    parameter int LEN   = LEN_DEFAULT,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int               CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    // Input side
    logic [CNT_W-1:0] accept_cnt;
    logic             cnt_last;
    logic             accept;

    // Stage 1
    logic [7:0]       a_q, b_q;
    logic             v1;
    logic             last1;
    logic             hold;

    // Multiplier / accumulator
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  acc, acc_base, acc_next;
    logic [ACC_W:0]    sum_ext;
    logic              ovf, ovf_next, carry;
    logic              first;
    logic              do_acc;
    state_t            state, state_next;

    assign cnt_last = (accept_cnt == LAST_CNT);
    assign in_ready = !(cnt_last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    // A completed term cannot land while an older result is still unclaimed.
    // For LEN > 1 the in_ready rule already makes this impossible; with LEN = 1
    // every term completes a group, so stage 1 freezes (and in_ready is low)
    // until the consumer takes the pending result.
    assign hold = v1 && last1 && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accept_cnt <= '0;
        end else if (accept) begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            accept_cnt <= cnt_last ? '0 : accept_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (!hold) begin
            v1 <= accept;
            if (accept) begin
                a_q   <= in_a;
                b_q   <= in_b;
                last1 <= cnt_last;
            end
        end
    end

    vedic8bit u_mul (
        .a (a_q),
        .b (b_q),
        .p (prod)
    );

    assign prod_ext = ACC_W'(prod);
    assign do_acc   = v1 && !hold;
    assign first    = (state == IDLE);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_next = state;
        acc_base   = first ? '0 : acc;
        sum_ext    = {1'b0, acc_base} + {1'b0, prod_ext};
        carry      = sum_ext[ACC_W];
        // The first term of a group cannot carry out (ACC_W >= PROD_W), and it
        // discards the previous group's flag.
        ovf_next   = carry || (!first && ovf);
`ifdef VMAC_SATURATE_EN
        acc_next   = ovf_next ? '1 : sum_ext[ACC_W-1:0];
`else
        acc_next   = sum_ext[ACC_W-1:0];
`endif
        if (do_acc) begin
            state_next = last1 ? IDLE : ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            if (do_acc) begin
                acc <= acc_next;
                ovf <= ovf_next;
            end
        end
    end

    // Output register: a new result may load in the same edge the old one is
    // taken, in which case out_valid simply stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (do_acc && last1) begin
            out_valid <= 1'b1;
            out_sum   <= acc_next;
            out_ovf   <= ovf_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vmac_dot_acc.sv
// Self-checking bench for vmac_dot_acc. Three instances cover LEN=4/ACC_W=24,
// LEN=2/ACC_W=16 and LEN=1/ACC_W=24. Inputs are driven and outputs sampled on
// the falling clock edge. Expected values come from plain arithmetic over the
// accepted operand stream (group sums of products, modulo or clamped).
module tb_vmac_dot_acc;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // LEN=4, ACC_W=24
    logic        iv4, ir4, ov4, or4, oo4;
    logic [7:0]  ia4, ib4;
    logic [23:0] os4;
    // LEN=2, ACC_W=16
    logic        iv2, ir2, ov2, or2, oo2;
    logic [7:0]  ia2, ib2;
    logic [15:0] os2;
    // LEN=1, ACC_W=24
    logic        iv1, ir1, ov1, or1, oo1;
    logic [7:0]  ia1, ib1;
    logic [23:0] os1;

    vmac_dot_acc #(.LEN(4), .ACC_W(24)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_a(ia4), .in_b(ib4),
        .out_valid(ov4), .out_ready(or4), .out_sum(os4), .out_ovf(oo4)
    );
    vmac_dot_acc #(.LEN(2), .ACC_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_a(ia2), .in_b(ib2),
        .out_valid(ov2), .out_ready(or2), .out_sum(os2), .out_ovf(oo2)
    );
    vmac_dot_acc #(.LEN(1), .ACC_W(24)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_a(ia1), .in_b(ib1),
        .out_valid(ov1), .out_ready(or1), .out_sum(os1), .out_ovf(oo1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic put4(input logic [7:0] a, input logic [7:0] b);
        iv4 = 1'b1; ia4 = a; ib4 = b;
    endtask

    // Reference: unsigned group sum reduced to w bits, wrapping or clamping.
    function automatic longint ref_sum(input longint raw, input int w);
        longint lim = longint'(1) << w;
`ifdef VMAC_SATURATE_EN
        return (raw >= lim) ? lim - 1 : raw;
`else
        return raw % lim;
`endif
    endfunction

    logic [7:0] t_a [4] = '{8'd1, 8'd2, 8'd255, 8'd0};
    logic [7:0] t_b [4] = '{8'd1, 8'd3, 8'd255, 8'd7};

    initial begin
        logic [24:0] expq [$];
        logic [24:0] exp_e;
        longint      gsum;
        int          gcnt;
        int          idx;
        int          pulses;
        int          results;
        logic [23:0] seen_sum;

        iv4 = 0; ia4 = 0; ib4 = 0; or4 = 1;
        iv2 = 0; ia2 = 0; ib2 = 0; or2 = 1;
        iv1 = 0; ia1 = 0; ib1 = 0; or1 = 1;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_in_ready", ir4, 1);
        check("rst_out_valid", ov4, 0);
        check("rst_out_sum", os4, 0);
        check("rst_out_ovf", oo4, 0);
        rst_n = 1'b1;
        tick();

        // ---- 1: LEN=4 back-to-back, 1+6+65025+0 = 65032 ----
        for (int i = 0; i < 4; i++) begin
            put4(t_a[i], t_b[i]);
            tick();
        end
        iv4 = 1'b0;
        check("t1_not_early", ov4, 0);
        tick();
        check("t1_valid", ov4, 1);
        check("t1_sum", os4, 65032);
        check("t1_ovf", oo4, 0);
        tick();
        check("t1_pulse_end", ov4, 0);

        // ---- 2: backpressure, 8 pairs of (2,2) ----
        or4 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            put4(8'd2, 8'd2);
            check("t2_ready_nonfinal", ir4, 1);
            tick();
        end
        put4(8'd2, 8'd2);
        for (int i = 0; i < 3; i++) begin
            check("t2_stall", ir4, 0);
            check("t2_hold_valid", ov4, 1);
            check("t2_hold_sum", os4, 16);
            tick();
        end
        or4 = 1'b1;
        #1;
        check("t2_release", ir4, 1);
        tick();
        iv4 = 1'b0;
        check("t2_drained", ov4, 0);
        tick();
        check("t2_second_valid", ov4, 1);
        check("t2_second_sum", os4, 16);
        tick();
        check("t2_second_end", ov4, 0);

        // ---- 3: ACC_W=16 overflow, then flag clears on next group ----
        iv2 = 1'b1; ia2 = 8'd255; ib2 = 8'd255;
        tick();
        tick();
        iv2 = 1'b0;
        tick();
        check("t3_valid", ov2, 1);
        check("t3_sum", os2, 32'(ref_sum(longint'(255 * 255 * 2), 16)));
        check("t3_ovf", oo2, 1);
        iv2 = 1'b1; ia2 = 8'd1; ib2 = 8'd1;
        tick();
        tick();
        iv2 = 1'b0;
        tick();
        check("t3_next_sum", os2, 2);
        check("t3_next_ovf", oo2, 0);

        // ---- 6: LEN=1, one result per cycle ----
        iv1 = 1'b1; ia1 = 8'd13; ib1 = 8'd17;
        check("t6_ready0", ir1, 1);
        tick();
        ia1 = 8'd255; ib1 = 8'd1;
        check("t6_ready1", ir1, 1);
        tick();
        ia1 = 8'd0; ib1 = 8'd0;
        check("t6_ready2", ir1, 1);
        check("t6_sum0", os1, 221);
        tick();
        iv1 = 1'b0;
        check("t6_ready3", ir1, 1);
        check("t6_valid1", ov1, 1);
        check("t6_sum1", os1, 255);
        tick();
        check("t6_valid2", ov1, 1);
        check("t6_sum2", os1, 0);
        tick();
        check("t6_end", ov1, 0);

        // ---- 4: reset mid-group discards partial sum ----
        put4(8'd9, 8'd9);
        tick();
        tick();
        iv4 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t4_rst_sum", os4, 0);
        check("t4_rst_valid", ov4, 0);
        check("t4_rst_ovf", oo4, 0);
        check("t4_rst_ready", ir4, 1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put4(8'(2 * i + 1), 8'(2 * i + 2));
            tick();
        end
        iv4 = 1'b0;
        check("t4_not_early", ov4, 0);
        tick();
        check("t4_valid", ov4, 1);
        check("t4_sum", os4, 100);
        tick();
        check("t4_end", ov4, 0);

        // ---- 5: random in_valid bubbles, same pairs as test 1 ----
        idx = 0;
        pulses = 0;
        seen_sum = '0;
        for (int c = 0; c < 30; c++) begin
            if (ov4) begin
                pulses++;
                seen_sum = os4;
            end
            if (idx < 4 && (c >= 12 || $urandom_range(0, 1) == 1)) begin
                put4(t_a[idx], t_b[idx]);
                idx++;
            end else begin
                iv4 = 1'b0;
            end
            tick();
        end
        check("t5_all_sent", idx, 4);
        check("t5_pulses", pulses, 1);
        check("t5_sum", seen_sum, 65032);

        // ---- random traffic with random backpressure against the model ----
        gsum = 0;
        gcnt = 0;
        results = 0;
        for (int c = 0; c < 1500; c++) begin
            iv4 = ($urandom_range(0, 3) != 0);
            ia4 = 8'($urandom);
            ib4 = 8'($urandom);
            or4 = ($urandom_range(0, 3) != 0);
            #1;
            check("rnd_ready", ir4, !(gcnt == 3 && ov4 && !or4));
            if (ov4 && or4) begin
                if (expq.size() == 0) begin
                    check("rnd_unexpected", 1, 0);
                end else begin
                    exp_e = expq.pop_front();
                    check("rnd_sum", os4, exp_e[23:0]);
                    check("rnd_ovf", oo4, exp_e[24]);
                    results++;
                end
            end
            if (iv4 && ir4) begin
                gsum += longint'(ia4) * longint'(ib4);
                gcnt++;
                if (gcnt == 4) begin
                    expq.push_back({gsum >= (longint'(1) << 24), 24'(ref_sum(gsum, 24))});
                    gsum = 0;
                    gcnt = 0;
                end
            end
            tick();
        end
        iv4 = 1'b0;
        or4 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (ov4 && expq.size() != 0) begin
                exp_e = expq.pop_front();
                check("rnd_tail_sum", os4, exp_e[23:0]);
                results++;
            end
            tick();
        end
        check("rnd_drained", expq.size(), 0);
        check("rnd_some_results", (results > 50), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
